// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;
   typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
   localparam int LEN_BYTES = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int MAX_WORDS = 65535;
   typedef logic [7:0] csum_t;
   function automatic logic takes_bytes(input state_t s);
      return s == S_LEN_LO || s == S_LEN_HI || s == S_DATA || s == S_CSUM;
   endfunction
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects four bytes little-endian; word_valid/word present the completed word
// combinationally on the accept of the fourth byte so the caller can register the write.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);
   logic [1:0]  cnt;
   logic [23:0] lanes;
   assign word_valid = byte_valid && cnt == 2'(BYTES_PER_WORD - 1);
   assign word = {byte_in, lanes};
   // Right-shifting in each byte leaves byte 0 in the lowest lane after three bytes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         lanes <= '0;
      end else if (clear) begin
         cnt <= '0;
         lanes <= '0;
      end else if (byte_valid) begin
         cnt <= cnt + 2'd1;
         lanes <= {byte_in, lanes[23:8]};
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader; parses a length-prefixed, XOR-checked byte frame into imem writes
// and releases the core from reset only after a verified load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int n = 32,
   parameter int depth = 1024,
   localparam int ADDR_W = $clog2(depth)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [n-1:0]      imem_wdata,
   output logic              core_reset_n,
   output logic              done,
   output logic              error
);
   localparam logic [16:0] DEPTH_L = 17'(depth);
   state_t      state, nxt;
   logic [7:0]  len_lo;
   logic [15:0] count, widx, len_word;
   csum_t       csum;
   logic        acc, reload_ok, asm_valid;
   logic [31:0] asm_word;
   assign acc = rx_valid && rx_ready;
   assign len_word = {rx_data, len_lo};
   assign reload_ok = reload && (state == S_DONE || state == S_ERR);
   word_assembler u_asm (
      .clk(clk),
      .reset_n(reset_n),
      .clear(reload_ok),
      .byte_valid(acc && state == S_DATA),
      .byte_in(rx_data),
      .word_valid(asm_valid),
      .word(asm_word)
   );
   always_comb begin
      nxt = state;
      case (state)
         S_LEN_LO: nxt = acc ? S_LEN_HI : state;
         S_LEN_HI: nxt = !acc ? state : {1'b0, len_word} > DEPTH_L ? S_ERR : len_word == '0 ? S_CSUM : S_DATA;
         S_DATA:   nxt = asm_valid && widx == count - 16'd1 ? S_CSUM : state;
         S_CSUM:   nxt = !acc ? state : rx_data == csum ? S_DONE : S_ERR;
         default:  nxt = reload ? S_LEN_LO : state;
      endcase
   end
   // All status outputs are registered from the next state, so they move the cycle after the deciding byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_LEN_LO;
         rx_ready <= 1'b0;
         imem_we <= 1'b0;
         imem_addr <= '0;
         imem_wdata <= '0;
         core_reset_n <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
         len_lo <= '0;
         count <= '0;
         widx <= '0;
         csum <= '0;
      end else begin
         state <= nxt;
         rx_ready <= takes_bytes(nxt);
         done <= nxt == S_DONE;
         error <= nxt == S_ERR;
         core_reset_n <= nxt == S_DONE;
         imem_we <= asm_valid;
         if (asm_valid) begin
            imem_addr <= widx[ADDR_W-1:0];
            imem_wdata <= asm_word;
            widx <= widx + 16'd1;
         end
         if (acc && state == S_LEN_LO) len_lo <= rx_data;
         if (acc && state == S_LEN_HI) count <= len_word;
         if (acc && state == S_DATA) csum <= csum ^ rx_data;
         if (reload_ok) begin
            len_lo <= '0;
            count <= '0;
            widx <= '0;
            csum <= '0;
         end
      end
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the writer side of the instruction memory that the rv32i core reads.
- Accepts a byte stream on a valid/ready interface, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from word address 0.
- Holds the core in reset until a checksum-verified load completes.
- Sits beside the core top, between a byte source (UART receiver or testbench) and the imem write port.

Parameters:
- n, 32, instruction/data word width; loader supports only 32.
- depth, 1024, instruction memory depth in words; must be ≤ 65535.
- ADDR_W, $clog2(depth), imem word-address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  byte source has a byte.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to restart loading from DONE or ERR.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  n  word to write.
- core_reset_n  out  1  active-low reset to the core; low until a successful load.
- done  out  1  load completed, checksum matched.
- error  out  1  load aborted: bad length or bad checksum.

Behaviour:
- Interface: one clock, clk; reset is asynchronous, active-low, reset_n.
- Frame format: LEN_LO, LEN_HI (16-bit word count, LE), then 4·count payload bytes (each word LE), then 1 checksum byte = XOR of all payload bytes.
- Byte accepted iff rx_valid && rx_ready at the rising edge. rx_valid gaps are allowed; there is no timeout.
- Reset values:
  - State LEN_LO.
  - rx_ready=0 during reset, 1 in the first cycle after release.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset_n=0 (async-cleared flop), done=0, error=0.
  - Counters and checksum 0.
- FSM states: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- rx_ready=1 in LEN_LO/LEN_HI/DATA/CSUM; 0 in DONE/ERR.
- LEN_LO: on accept, latch the low byte → LEN_HI.
- LEN_HI: on accept, form the count:
  - count > depth → ERR;
  - count == 0 → CSUM;
  - else → DATA.
- DATA:
  - Byte counter 0..3; each accepted byte is placed in lane [8·k+7:8·k] and XORed into the checksum.
  - On the 4th byte: next cycle imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=word index; word index increments.
  - After the last word's 4th byte → CSUM.
  - Write latency is one cycle after the final byte's accept. No backpressure to imem.
- CSUM: on accept, compare against the running XOR.
  - Match → DONE.
  - Mismatch → ERR.
- DONE: done=1, core_reset_n=1, both registered and asserted the cycle after the checksum accept.
- ERR: error=1, core_reset_n stays 0.
- reload:
  - Honoured only in DONE/ERR. Next cycle: state LEN_LO; done, error, core_reset_n=0; counters and checksum cleared.
  - Ignored in all other states.
- reset_n low mid-frame: immediate abort, all outputs to reset values, partial word discarded. After release the next load starts at address 0.
- imem_addr holds its last value when imem_we=0.

Decomposition:
- Package imem_loader_pkg:
  - state enum type;
  - LEN_BYTES=2, BYTES_PER_WORD=4, MAX_WORDS=65535;
  - checksum type (8-bit).
- One sub-module, word_assembler:
  - 2-bit byte counter and 32-bit LE shift/lane register;
  - ports clk, reset_n, clear, byte_valid, byte_in → word_valid pulse and word.
- The FSM, word index, and checksum stay in imem_loader.

Test Plan:
- Two words: 02 00 EF BE AD DE 78 56 34 12 2A → writes [0]=0xDEADBEEF, [1]=0x12345678, one imem_we pulse each; done=1 and core_reset_n=1 one cycle after the 0x2A accept; rx_ready=0 afterwards.
- Same frame with checksum 0x2B → no done; error=1, core_reset_n=0, rx_ready=0; both words still written.
- Empty frame 00 00 00 → done=1, zero imem_we pulses.
- Oversize 01 04 (count 1025, depth 1024) → error=1 the cycle after the second byte; no writes; later bytes not accepted.
- Two-word frame with random rx_valid bubbles and reset_n pulsed low after 6 payload bytes → all outputs clear immediately; a fresh full frame then writes from address 0 and reaches done.
- In DONE, pulse reload → core_reset_n=0 and done=0 next cycle, rx_ready=1. Load one word 01 00 13 00 00 00 13 → [0]=0x00000013, done=1. A reload pulse in DATA has no effect.
